// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Contents: FSM state enum, BCD digit width, add-3 threshold, and a
// constant clog2 helper used to size the shift counter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W     = 4;
  localparam logic [3:0]  ADD3_THRESH = 4'd5;

  // Smallest r with 2**r >= value; elaboration-time only.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
// Ports:
//   i_digit  in   4  scratch digit before correction
//   o_digit  out  4  corrected digit (i_digit + 3 when i_digit >= 5)
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  // Input is at most 9 in a valid scratch, so the 4-bit sum cannot wrap.
  assign o_digit = (i_digit >= ADD3_THRESH) ? i_digit + DIGIT_W'(3) : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble).
// One input bit is consumed per cycle; results appear with a one-cycle done
// pulse and hold until the next conversion finishes.
// Optional feature: define LZ_BLANK_EN to generate the leading-zero blank
// mask; without it blank is tied to 0.
// Ports:
//   clk    in   1             rising-edge clock
//   rst    in   1             synchronous active-high reset
//   start  in   1             conversion request, honoured in IDLE or DONE
//   bin    in   BIN_W         unsigned value captured when start is accepted
//   busy   out  1             high while shifting
//   done   out  1             one-cycle pulse when bcd/blank update
//   bcd    out  4*NUM_DIGITS  packed BCD digits, ones digit in [3:0]
//   blank  out  NUM_DIGITS    1 = leading-zero digit to be blanked
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W      = 10,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [DIGIT_W*NUM_DIGITS-1:0] bcd,
  output logic [NUM_DIGITS-1:0]         blank
);

  localparam int unsigned SCR_W = DIGIT_W * NUM_DIGITS;
  localparam int unsigned CNT_W = clog2(BIN_W + 1);

  // NUM_DIGITS >= ceil(BIN_W * log10(2)), in integer form.
  if (NUM_DIGITS * 100000 < BIN_W * 30103) begin : g_digits_check
    $error("bin_to_bcd_seq: NUM_DIGITS too small for BIN_W");
  end

  state_t             r_state;
  logic [BIN_W-1:0]   r_shreg;
  logic [SCR_W-1:0]   r_scr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [SCR_W-1:0]   r_bcd;

  logic [SCR_W-1:0]   w_adj;
  logic [SCR_W-1:0]   w_scr_nxt;
  logic [BIN_W-1:0]   w_sh_nxt;
  logic               w_unused;

  // Per-digit add-3 correction ahead of the shift.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_scr[DIGIT_W*g +: DIGIT_W]),
      .o_digit (w_adj[DIGIT_W*g +: DIGIT_W])
    );
  end

  // Shift {scratch, shreg} left by one; the bit falling off the top is
  // always 0 because the scratch is sized for the full input range.
  assign {w_unused, w_scr_nxt, w_sh_nxt} = {w_adj, r_shreg, 1'b0};

`ifdef LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] r_blank;
  logic [NUM_DIGITS-1:0] w_blank;
  logic                  w_run;

  // Digit i blanks when it and every higher digit are zero; ones never blanks.
  always_comb begin
    w_blank = '0;
    w_run   = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      w_run      = w_run & (w_scr_nxt[DIGIT_W*i +: DIGIT_W] == '0);
      w_blank[i] = w_run;
    end
  end

  assign blank = r_blank;
`else
  assign blank = '0;
`endif

  // Control FSM and datapath; bcd/blank/done are loaded on the final shift
  // edge so they are visible during the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
`ifdef LZ_BLANK_EN
      r_blank <= ~NUM_DIGITS'(1);
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_shreg <= bin;
            r_scr   <= '0;
            r_cnt   <= CNT_W'(BIN_W);
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_scr   <= w_scr_nxt;
          r_shreg <= w_sh_nxt;
          r_cnt   <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_bcd   <= w_scr_nxt;
`ifdef LZ_BLANK_EN
            r_blank <= w_blank;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule
